// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin arbiter/sequencer sharing one ALU between two requesters.
// Ports: req/op/sw per requester in, done pulses out; ALU_OP/AB_SW to ALU, F/ZF/OF back, captured *_OUT.
module alu_share_arb #(
  parameter int WIDTH = 32,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [2:0]       op0,
  input  logic [2:0]       op1,
  input  logic [2:0]       sw0,
  input  logic [2:0]       sw1,
  output logic             done0,
  output logic             done1,
  output logic             busy,
  output logic [WIDTH-1:0] F_OUT,
  output logic             ZF_OUT,
  output logic             OF_OUT,
  output logic [2:0]       ALU_OP,
  output logic [2:0]       AB_SW,
  input  logic [WIDTH-1:0] F,
  input  logic             ZF,
  input  logic             OF
);

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [2:0]       op_q, op_d;
  logic [2:0]       sw_q, sw_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic             zf_q, zf_d;
  logic             of_q, of_d;
  logic [1:0]       done_q, done_d;

  logic gnt0, gnt1;

  // On contention the requester that did not win last time is served.
  assign gnt0 = req0 & (~req1 | last_q);
  assign gnt1 = req1 & (~req0 | ~last_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    op_d    = op_q;
    sw_d    = sw_q;
    f_d     = f_q;
    zf_d    = zf_q;
    of_d    = of_q;
    done_d  = 2'b00;
    case (state_q)
      IDLE: begin
        unique case (1'b1)
          gnt0: begin
            owner_d = 1'b0;
            last_d  = 1'b0;
            op_d    = op0;
            sw_d    = sw0;
            cnt_d   = CNT_INIT;
            state_d = WAIT;
          end
          gnt1: begin
            owner_d = 1'b1;
            last_d  = 1'b1;
            op_d    = op1;
            sw_d    = sw1;
            cnt_d   = CNT_INIT;
            state_d = WAIT;
          end
          default: ;
        endcase
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          f_d             = F;
          zf_d            = ZF;
          of_d            = OF;
          done_d[owner_q] = 1'b1;
          state_d         = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      op_q    <= 3'd0;
      sw_q    <= 3'd0;
      f_q     <= '0;
      zf_q    <= 1'b0;
      of_q    <= 1'b0;
      done_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      op_q    <= op_d;
      sw_q    <= sw_d;
      f_q     <= f_d;
      zf_q    <= zf_d;
      of_q    <= of_d;
      done_q  <= done_d;
    end
  end

  assign busy   = (state_q == WAIT) | (state_q == DONE);
  assign done0  = done_q[0];
  assign done1  = done_q[1];
  assign F_OUT  = f_q;
  assign ZF_OUT = zf_q;
  assign OF_OUT = of_q;
  assign ALU_OP = op_q;
  assign AB_SW  = sw_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: randomized scoreboard bench for alu_share_arb.
// Instance A uses LAT=1, instance B uses LAT=4; each has its own ALU stub and monitor.
module tb_alu_share_arb;

  localparam int W    = 32;
  localparam int LATA = 1;
  localparam int LATB = 4;

  typedef struct {
    int          id;
    int          at;
    logic [W-1:0] f;
    logic        zf;
    logic        of;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic bound_fail(input string nm);
    n_total++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  // Reference: F is op concatenated above sw, i.e. op*8+sw.
  function automatic exp_t mk(input int id, input int at, input int op, input int sw);
    exp_t e;
    e.id = id;
    e.at = at;
    e.f  = W'(op * 8 + sw);
    e.zf = (op * 8 + sw) == 0;
    e.of = (op >= 4) && (sw % 2 == 1);
    return e;
  endfunction

  // ---------------- instance A ----------------
  logic         a_rst_n = 1'b0;
  logic         a_req0 = 0, a_req1 = 0;
  logic [2:0]   a_op0 = 0, a_op1 = 0, a_sw0 = 0, a_sw1 = 0;
  logic         a_done0, a_done1, a_busy, a_zfo, a_ofo, a_zf, a_of;
  logic [W-1:0] a_fo, a_f;
  logic [2:0]   a_aop, a_asw;

  assign a_f  = {{(W-6){1'b0}}, a_aop, a_asw};
  assign a_zf = (a_f == '0);
  assign a_of = a_aop[2] & a_asw[0];

  alu_share_arb #(.WIDTH(W), .LAT(LATA)) u_a (
    .clk(clk), .rst_n(a_rst_n),
    .req0(a_req0), .req1(a_req1),
    .op0(a_op0), .op1(a_op1), .sw0(a_sw0), .sw1(a_sw1),
    .done0(a_done0), .done1(a_done1), .busy(a_busy),
    .F_OUT(a_fo), .ZF_OUT(a_zfo), .OF_OUT(a_ofo),
    .ALU_OP(a_aop), .AB_SW(a_asw),
    .F(a_f), .ZF(a_zf), .OF(a_of)
  );

  // ---------------- instance B ----------------
  logic         b_rst_n = 1'b0;
  logic         b_req0 = 0, b_req1 = 0;
  logic [2:0]   b_op0 = 0, b_op1 = 0, b_sw0 = 0, b_sw1 = 0;
  logic         b_done0, b_done1, b_busy, b_zfo, b_ofo, b_zf, b_of;
  logic [W-1:0] b_fo, b_f;
  logic [2:0]   b_aop, b_asw;

  assign b_f  = {{(W-6){1'b0}}, b_aop, b_asw};
  assign b_zf = (b_f == '0);
  assign b_of = b_aop[2] & b_asw[0];

  alu_share_arb #(.WIDTH(W), .LAT(LATB)) u_b (
    .clk(clk), .rst_n(b_rst_n),
    .req0(b_req0), .req1(b_req1),
    .op0(b_op0), .op1(b_op1), .sw0(b_sw0), .sw1(b_sw1),
    .done0(b_done0), .done1(b_done1), .busy(b_busy),
    .F_OUT(b_fo), .ZF_OUT(b_zfo), .OF_OUT(b_ofo),
    .ALU_OP(b_aop), .AB_SW(b_asw),
    .F(b_f), .ZF(b_zf), .OF(b_of)
  );

  // ---------------- monitors ----------------
  exp_t         qa[$];
  exp_t         qb[$];
  logic [W-1:0] a_lastf = '0;
  logic [W-1:0] b_lastf = '0;
  int           a_run = 0;
  int           b_run = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!a_rst_n) begin
      a_lastf = '0;
      a_run   = 0;
    end else begin
      chk("A done exclusive", a_done0 & a_done1, 0);
      if (a_done0 | a_done1) begin
        chk("A done expected", qa.size() > 0, 1);
        if (qa.size() > 0) begin
          e = qa.pop_front();
          chk("A done id", a_done1, e.id);
          chk("A done cycle", cyc, e.at);
          chk("A F_OUT", a_fo, e.f);
          chk("A ZF_OUT", a_zfo, e.zf);
          chk("A OF_OUT", a_ofo, e.of);
          a_lastf = e.f;
        end
      end else begin
        chk("A F_OUT hold", a_fo, a_lastf);
      end
      if (a_busy) a_run++;
      else if (a_run != 0) begin
        chk("A busy length", a_run, LATA + 1);
        a_run = 0;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!b_rst_n) begin
      b_lastf = '0;
      b_run   = 0;
    end else begin
      chk("B done exclusive", b_done0 & b_done1, 0);
      if (b_done0 | b_done1) begin
        chk("B done expected", qb.size() > 0, 1);
        if (qb.size() > 0) begin
          e = qb.pop_front();
          chk("B done id", b_done1, e.id);
          chk("B done cycle", cyc, e.at);
          chk("B F_OUT", b_fo, e.f);
          chk("B ZF_OUT", b_zfo, e.zf);
          chk("B OF_OUT", b_ofo, e.of);
          b_lastf = e.f;
        end
      end else begin
        chk("B F_OUT hold", b_fo, b_lastf);
      end
      if (b_busy) b_run++;
      else if (b_run != 0) begin
        chk("B busy length", b_run, LATB + 1);
        b_run = 0;
      end
    end
  end

  // ---------------- stimulus for A ----------------
  int a_last = 1;

  // pat bit0 = req0, bit1 = req1; each request dropped when its done is seen.
  task automatic a_round(input int pat, input int o0, input int s0, input int o1, input int s1);
    int first, second, c, n;
    @(negedge clk);
    c = cyc;
    if (pat == 3) begin
      first  = 1 - a_last;
      second = a_last;
    end else begin
      first  = (pat == 2) ? 1 : 0;
      second = -1;
    end
    qa.push_back(mk(first, c + 1 + LATA, first ? o1 : o0, first ? s1 : s0));
    if (second >= 0)
      qa.push_back(mk(second, c + 3 + 2 * LATA, second ? o1 : o0, second ? s1 : s0));
    a_last = (second >= 0) ? second : first;
    a_op0 = 3'(o0); a_sw0 = 3'(s0); a_op1 = 3'(o1); a_sw1 = 3'(s1);
    a_req0 = pat[0];
    a_req1 = pat[1];
    @(negedge clk);
    chk("A ALU_OP after grant", a_aop, first ? o1 : o0);
    chk("A AB_SW after grant", a_asw, first ? s1 : s0);
    n = 0;
    while (a_req0 | a_req1) begin
      @(negedge clk);
      if (a_done0) a_req0 = 0;
      if (a_done1) a_req1 = 0;
      n++;
      if (n > 40) begin
        bound_fail("A round");
        a_req0 = 0;
        a_req1 = 0;
      end
    end
  endtask

  // Both requests held through six operations.
  task automatic a_held6();
    int c, f, id, n, seen;
    int o[2], s[2];
    @(negedge clk);
    c = cyc;
    f = 1 - a_last;
    for (int k = 0; k < 2; k++) begin
      o[k] = $urandom_range(0, 7);
      s[k] = $urandom_range(0, 7);
    end
    for (int k = 0; k < 6; k++) begin
      id = (k % 2 == 0) ? f : 1 - f;
      qa.push_back(mk(id, c + 1 + LATA + k * (LATA + 2), o[id], s[id]));
      a_last = id;
    end
    a_op0 = 3'(o[0]); a_sw0 = 3'(s[0]); a_op1 = 3'(o[1]); a_sw1 = 3'(s[1]);
    a_req0 = 1;
    a_req1 = 1;
    n = 0;
    seen = 0;
    while (seen < 6 && n < 6 * (LATA + 2) + 10) begin
      @(negedge clk);
      if (a_done0 | a_done1) seen++;
      n++;
    end
    if (seen < 6) bound_fail("A held6");
    a_req0 = 0;
    a_req1 = 0;
  endtask

  // req0 kept one IDLE cycle past done0 issues a second identical operation.
  task automatic a_hold_extra();
    int c, cnt, da, o, s;
    @(negedge clk);
    c = cyc;
    o = $urandom_range(0, 7);
    s = $urandom_range(0, 7);
    qa.push_back(mk(0, c + 1 + LATA, o, s));
    qa.push_back(mk(0, c + 3 + 2 * LATA, o, s));
    a_last = 0;
    a_op0 = 3'(o); a_sw0 = 3'(s);
    a_req0 = 1;
    cnt = 0;
    da = -1;
    for (int i = 0; i < 2 * LATA + 8; i++) begin
      @(negedge clk);
      if (a_done0) begin
        cnt++;
        if (cnt == 1) da = i + 2;
      end
      if (i == da) a_req0 = 0;
    end
    a_req0 = 0;
    chk("A extra-hold done0 count", cnt, 2);
  endtask

  // ---------------- stimulus for B ----------------
  task automatic b_single1(input int o1, input int s1, input int late_op);
    int c, n;
    @(negedge clk);
    c = cyc;
    qb.push_back(mk(1, c + 1 + LATB, o1, s1));
    b_op1 = 3'(o1); b_sw1 = 3'(s1);
    b_req1 = 1;
    n = 0;
    while (b_req1) begin
      @(negedge clk);
      n++;
      if (n == 2 && late_op >= 0) b_op1 = 3'(late_op);
      if (b_done1) b_req1 = 0;
      if (n > 40) begin
        bound_fail("B round");
        b_req1 = 0;
      end
    end
  endtask

  task automatic b_reset_mid_wait();
    @(negedge clk);
    b_op1 = 3'b110; b_sw1 = 3'b011;
    b_req1 = 1;
    @(negedge clk);
    @(negedge clk);
    chk("B busy in WAIT", b_busy, 1);
    #2 b_rst_n = 0;
    #1;
    chk("B rst done0", b_done0, 0);
    chk("B rst done1", b_done1, 0);
    chk("B rst busy", b_busy, 0);
    chk("B rst F_OUT", b_fo, 0);
    chk("B rst ZF_OUT", b_zfo, 0);
    chk("B rst OF_OUT", b_ofo, 0);
    chk("B rst ALU_OP", b_aop, 0);
    chk("B rst AB_SW", b_asw, 0);
    b_req1 = 0;
    repeat (2) @(negedge clk);
    b_rst_n = 1;
    repeat (8) @(negedge clk);
  endtask

  // ---------------- main sequences ----------------
  task automatic reset_checks();
    chk("A reset busy", a_busy, 0);
    chk("A reset done", {a_done1, a_done0}, 0);
    chk("A reset F_OUT", a_fo, 0);
    chk("A reset flags", {a_zfo, a_ofo}, 0);
    chk("A reset ALU_OP/AB_SW", {a_aop, a_asw}, 0);
    chk("B reset busy", b_busy, 0);
    chk("B reset F_OUT", b_fo, 0);
    chk("B reset ALU_OP/AB_SW", {b_aop, b_asw}, 0);
  endtask

  logic a_fin = 0;
  logic b_fin = 0;

  initial begin
    repeat (3) @(negedge clk);
    reset_checks();
    a_rst_n = 1;
    a_round(1, 1, 1, 0, 0);
    a_round(2, 0, 0, 5, 2);
    a_round(3, 2, 2, 7, 7);
    a_held6();
    a_hold_extra();
    for (int r = 0; r < 60; r++) begin
      a_round($urandom_range(1, 3), $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 7), $urandom_range(0, 7));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    a_fin = 1;
  end

  initial begin
    repeat (3) @(negedge clk);
    b_rst_n = 1;
    b_single1(0, 0, 5);
    b_reset_mid_wait();
    for (int r = 0; r < 10; r++)
      b_single1($urandom_range(0, 7), $urandom_range(0, 7), -1);
    b_fin = 1;
  end

  initial begin
    int t;
    t = 0;
    while (!(a_fin && b_fin) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (!(a_fin && b_fin)) bound_fail("global");
    repeat (5) @(negedge clk);
    chk("A queue drained", qa.size(), 0);
    chk("B queue drained", qb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Two-requester arbiter and sequencer that shares the single `alu` datapath. It accepts an operation request (`ALU_OP` code plus `AB_SW` operand select) from either requester and grants the ALU round-robin. It drives the ALU inputs, waits a fixed settle time, then captures `F`, `ZF` and `OF` into result registers and returns a one-cycle completion pulse to the owner. It sits between the control/test logic and the ALU instance.

## Interface
- `WIDTH`, 32: width of ALU result `F` and `F_OUT`.
- `LAT`, 1: ALU settle cycles between driving `ALU_OP`/`AB_SW` and sampling results. Legal range 1–15; the counter is 4 bits.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0`, `req1`  in  1  request level from requester 0 / 1.
- `op0`, `op1`  in  3  ALU operation code from requester 0 / 1.
- `sw0`, `sw1`  in  3  operand-select code from requester 0 / 1.
- `done0`, `done1`  out  1  one-cycle completion pulse to requester 0 / 1.
- `busy`  out  1  high while an operation is in flight (WAIT or DONE).
- `F_OUT`  out  WIDTH  captured ALU result.
- `ZF_OUT`, `OF_OUT`  out  1  captured zero and overflow flags.
- `ALU_OP`  out  3  registered operation code driven to `alu`.
- `AB_SW`  out  3  registered operand select driven to `alu`.
- `F`  in  WIDTH  result from `alu`.
- `ZF`, `OF`  in  1  flags from `alu`.

## Operation
- FSM states: IDLE, WAIT, DONE.
- **IDLE.**
  - If no `req` is high, the FSM stays in IDLE.
  - If exactly one `reqN` is high, grant N.
  - If both are high, grant the requester that is not `last_gnt`.
  - On grant: register `ALU_OP<=opN`, `AB_SW<=swN`, `owner<=N`, `last_gnt<=N`, `cnt<=LAT-1`, then go to WAIT.
  - `opN`/`swN` are sampled only at the grant edge. Later changes are ignored.
- **WAIT.**
  - If `cnt!=0`: decrement `cnt`.
  - If `cnt==0`: capture `F_OUT<=F`, `ZF_OUT<=ZF`, `OF_OUT<=OF`, set `done[owner]<=1`, go to DONE.
- **DONE.**
  - `done[owner]` is high for exactly this cycle. It clears on the next edge.
  - The FSM returns to IDLE. Requests are ignored in DONE.
- **Requester rules.**
  - Hold `reqN` high until `doneN` is seen.
  - Deassert `reqN` before the edge that ends the DONE cycle.
  - A `reqN` still high in the following IDLE cycle is a new request.
- **Holding values.**
  - `ALU_OP` and `AB_SW` hold their last granted values between operations.
  - `F_OUT`, `ZF_OUT` and `OF_OUT` hold until the next capture.
- `busy` = (state==WAIT) | (state==DONE).
- Fairness: with both requests held continuously, grants strictly alternate 0,1,0,1…
- **Reset.**
  - Asynchronous assertion of `rst_n` forces IDLE.
  - All outputs (`done0`, `done1`, `busy`, `F_OUT`, `ZF_OUT`, `OF_OUT`, `ALU_OP`, `AB_SW`) go to 0.
  - `last_gnt`=1, so requester 0 wins the first contention.
  - `cnt`=0 and `owner`=0.
  - Reset mid-operation aborts it; no `done` is issued for the aborted request.

## Timing
- Grant edge E0: the IDLE cycle samples `reqN`. `ALU_OP`/`AB_SW` are valid from E0 onward.
- Results are captured at edge E0+LAT.
- `doneN` is high during cycle E0+LAT → E0+LAT+1. Results are valid from E0+LAT.
- FSM is back in IDLE at edge E0+LAT+1. The next grant is earliest at edge E0+LAT+2.
- Throughput: one operation per LAT+2 cycles.
- `done0` and `done1` are never high in the same cycle.
- `busy` is 1 for exactly LAT+1 cycles per operation.

## Test plan
Bench ALU stub: `F={(WIDTH-6)'b0, ALU_OP, AB_SW}`, `ZF=(F==0)`, `OF=ALU_OP[2]&AB_SW[0]`.

1. Reset, then `req0=1`, `op0=3'b001`, `sw0=3'b001` with LAT=1 → `ALU_OP=001`, `AB_SW=001` one cycle after grant. Next cycle `done0=1`, `F_OUT=32'h09`, `ZF_OUT=0`, `OF_OUT=0`. `busy` high for 2 cycles.
2. `req0` and `req1` rise together, with `op0=3'b010`, `sw0=3'b010` and `op1=3'b111`, `sw1=3'b111` → requester 0 is served first (`F_OUT=32'h12`, `done0`). Then requester 1 (`F_OUT=32'h3F`, `OF_OUT=1`, `done1`). Gap between the two done pulses is LAT+2 cycles.
3. Both requests held for 6 operations → done order 0,1,0,1,0,1. Never both done pulses in one cycle.
4. LAT=4, `op1=3'b000`, `sw1=3'b000`; change `op1` to 3'b101 two cycles after grant → `done1` exactly 4 cycles after the grant edge. `F_OUT=0`, `ZF_OUT=1`. The late `op1` change is ignored.
5. Pull `rst_n` low during WAIT → all outputs read 0 immediately (asynchronously). No `done` pulse. After release with only `req1` high, requester 1 is granted normally.
6. After `done0`, hold `req0` one extra cycle → a second operation is issued with identical results. Bench asserts exactly two `done0` pulses.
